// File: rtl/cle_label_stats.sv
// cle_label_stats: per-label area / bounding-box statistics over a label map.
//
// Runs after the connected-component labeler finishes. It scans the
// 2^IMG_LOG2 x 2^IMG_LOG2 label map held in SRAM (one 8-bit label per pixel,
// 0 = background). While scanning it accumulates area and bounding box for
// labels 1..MAX_LABELS. It then emits one record per present label, in
// ascending label order, on a valid/ready stream.
//
// Optional feature: define CLE_LABEL_STATS_CENTROID_EN to add per-label
// sum_x / sum_y accumulators and the rec_sumx / rec_sumy outputs.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   start             one-cycle pulse that begins a scan (ignored while busy)
//   sram_a / sram_q   SRAM read address / data (data valid one cycle later)
//   busy              high from the cycle after start is accepted until done
//   done              one-cycle pulse after the last record is accepted
//   overflow          sticky per scan: a label > MAX_LABELS was seen
//   rec_valid/ready   record stream handshake
//   rec_label, rec_area, rec_xmin/xmax/ymin/ymax   record fields
//   rec_sumx, rec_sumy                             (centroid build only)
module cle_label_stats #(
  parameter int unsigned MAX_LABELS = 16,
  parameter int unsigned IMG_LOG2   = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            sram_q,
  output logic [2*IMG_LOG2-1:0] sram_a,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic                  rec_valid,
  input  logic                  rec_ready,
  output logic [7:0]            rec_label,
  output logic [2*IMG_LOG2:0]   rec_area,
  output logic [IMG_LOG2-1:0]   rec_xmin,
  output logic [IMG_LOG2-1:0]   rec_xmax,
  output logic [IMG_LOG2-1:0]   rec_ymin,
  output logic [IMG_LOG2-1:0]   rec_ymax
`ifdef CLE_LABEL_STATS_CENTROID_EN
  ,
  output logic [3*IMG_LOG2-1:0] rec_sumx,
  output logic [3*IMG_LOG2-1:0] rec_sumy
`endif
);

  localparam int unsigned AW   = 2 * IMG_LOG2;
  localparam int unsigned CW   = 2 * IMG_LOG2 + 1;
  localparam int unsigned XW   = IMG_LOG2;
  localparam int unsigned IdxW = (MAX_LABELS > 1) ? $clog2(MAX_LABELS) : 1;
`ifdef CLE_LABEL_STATS_CENTROID_EN
  localparam int unsigned SW   = 3 * IMG_LOG2;
`endif

  localparam logic [AW-1:0] LastAddr = '1;
  localparam logic [7:0]    MaxLab   = 8'(MAX_LABELS);

  typedef enum logic [1:0] {StIdle, StScan, StFlush, StEmit} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   sram_a_q, sram_a_d;
  // Address pipeline: pairs the returning sram_q with the address issued last cycle.
  logic            pipe_v_q, pipe_v_d;
  logic [AW-1:0]   pipe_a_q, pipe_a_d;
  logic [7:0]      idx_q, idx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            ovf_q, ovf_d;
  logic            clear_tbl;
  logic            emit_last;

  logic            rec_valid_q, rec_valid_d;
  logic [7:0]      rec_label_q, rec_label_d;
  logic [CW-1:0]   rec_area_q, rec_area_d;
  logic [XW-1:0]   rec_xmin_q, rec_xmin_d;
  logic [XW-1:0]   rec_xmax_q, rec_xmax_d;
  logic [XW-1:0]   rec_ymin_q, rec_ymin_d;
  logic [XW-1:0]   rec_ymax_q, rec_ymax_d;

  // Statistics table, entry i holds label i+1.
  logic            tbl_valid_q [MAX_LABELS];
  logic [CW-1:0]   tbl_area_q  [MAX_LABELS];
  logic [XW-1:0]   tbl_xmin_q  [MAX_LABELS];
  logic [XW-1:0]   tbl_xmax_q  [MAX_LABELS];
  logic [XW-1:0]   tbl_ymin_q  [MAX_LABELS];
  logic [XW-1:0]   tbl_ymax_q  [MAX_LABELS];

`ifdef CLE_LABEL_STATS_CENTROID_EN
  logic [SW-1:0]   tbl_sumx_q  [MAX_LABELS];
  logic [SW-1:0]   tbl_sumy_q  [MAX_LABELS];
  logic [SW-1:0]   rec_sumx_q, rec_sumx_d;
  logic [SW-1:0]   rec_sumy_q, rec_sumy_d;
`endif

  // Pixel decode for the sample currently on sram_q.
  logic [XW-1:0]   pix_x, pix_y;
  logic [IdxW-1:0] pix_idx;
  logic            pix_upd, pix_ovf;
  logic [IdxW-1:0] emit_idx;

  assign pix_x    = pipe_a_q[XW-1:0];
  assign pix_y    = pipe_a_q[AW-1:XW];
  assign pix_idx  = IdxW'(sram_q - 8'd1);
  assign pix_upd  = pipe_v_q && (sram_q != 8'd0) && (sram_q <= MaxLab);
  assign pix_ovf  = pipe_v_q && (sram_q > MaxLab);
  assign emit_idx = IdxW'(idx_q - 8'd1);

  // Next-state and control
  always_comb begin
    state_d     = state_q;
    sram_a_d    = sram_a_q;
    pipe_v_d    = 1'b0;
    pipe_a_d    = pipe_a_q;
    idx_d       = idx_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    ovf_d       = ovf_q;
    clear_tbl   = 1'b0;
    emit_last   = 1'b0;
    rec_valid_d = rec_valid_q;
    rec_label_d = rec_label_q;
    rec_area_d  = rec_area_q;
    rec_xmin_d  = rec_xmin_q;
    rec_xmax_d  = rec_xmax_q;
    rec_ymin_d  = rec_ymin_q;
    rec_ymax_d  = rec_ymax_q;
`ifdef CLE_LABEL_STATS_CENTROID_EN
    rec_sumx_d  = rec_sumx_q;
    rec_sumy_d  = rec_sumy_q;
`endif

    if (pix_ovf) begin
      ovf_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        // done_q high means this is the done cycle; a coincident start is dropped.
        if (start && !done_q) begin
          clear_tbl = 1'b1;
          ovf_d     = 1'b0;
          sram_a_d  = '0;
          busy_d    = 1'b1;
          state_d   = StScan;
        end
      end
      StScan: begin
        pipe_v_d = 1'b1;
        pipe_a_d = sram_a_q;
        if (sram_a_q == LastAddr) begin
          state_d = StFlush;
        end else begin
          sram_a_d = sram_a_q + 1'b1;
        end
      end
      StFlush: begin
        // The final pixel is consumed this cycle via pipe_v_q.
        idx_d   = 8'd1;
        state_d = StEmit;
      end
      StEmit: begin
        if (!rec_valid_q) begin
          if (tbl_valid_q[emit_idx]) begin
            rec_valid_d = 1'b1;
            rec_label_d = idx_q;
            rec_area_d  = tbl_area_q[emit_idx];
            rec_xmin_d  = tbl_xmin_q[emit_idx];
            rec_xmax_d  = tbl_xmax_q[emit_idx];
            rec_ymin_d  = tbl_ymin_q[emit_idx];
            rec_ymax_d  = tbl_ymax_q[emit_idx];
`ifdef CLE_LABEL_STATS_CENTROID_EN
            rec_sumx_d  = tbl_sumx_q[emit_idx];
            rec_sumy_d  = tbl_sumy_q[emit_idx];
`endif
          end else if (idx_q == MaxLab) begin
            emit_last = 1'b1;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end else if (rec_ready) begin
          rec_valid_d = 1'b0;
          if (idx_q == MaxLab) begin
            emit_last = 1'b1;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
        if (emit_last) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      sram_a_q    <= '0;
      pipe_v_q    <= 1'b0;
      pipe_a_q    <= '0;
      idx_q       <= 8'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      rec_valid_q <= 1'b0;
      rec_label_q <= '0;
      rec_area_q  <= '0;
      rec_xmin_q  <= '0;
      rec_xmax_q  <= '0;
      rec_ymin_q  <= '0;
      rec_ymax_q  <= '0;
`ifdef CLE_LABEL_STATS_CENTROID_EN
      rec_sumx_q  <= '0;
      rec_sumy_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sram_a_q    <= sram_a_d;
      pipe_v_q    <= pipe_v_d;
      pipe_a_q    <= pipe_a_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
      rec_valid_q <= rec_valid_d;
      rec_label_q <= rec_label_d;
      rec_area_q  <= rec_area_d;
      rec_xmin_q  <= rec_xmin_d;
      rec_xmax_q  <= rec_xmax_d;
      rec_ymin_q  <= rec_ymin_d;
      rec_ymax_q  <= rec_ymax_d;
`ifdef CLE_LABEL_STATS_CENTROID_EN
      rec_sumx_q  <= rec_sumx_d;
      rec_sumy_q  <= rec_sumy_d;
`endif
    end
  end

  // Entry valid bits: only these need clearing, the data is rewritten on first hit.
  always_ff @(posedge clk) begin
    if (reset || clear_tbl) begin
      for (int i = 0; i < int'(MAX_LABELS); i++) begin
        tbl_valid_q[i] <= 1'b0;
      end
    end else if (pix_upd) begin
      tbl_valid_q[pix_idx] <= 1'b1;
    end
  end

  // Entry data
  always_ff @(posedge clk) begin
    if (pix_upd) begin
      if (!tbl_valid_q[pix_idx]) begin
        tbl_area_q[pix_idx] <= CW'(1);
        tbl_xmin_q[pix_idx] <= pix_x;
        tbl_xmax_q[pix_idx] <= pix_x;
        tbl_ymin_q[pix_idx] <= pix_y;
        tbl_ymax_q[pix_idx] <= pix_y;
`ifdef CLE_LABEL_STATS_CENTROID_EN
        tbl_sumx_q[pix_idx] <= SW'(pix_x);
        tbl_sumy_q[pix_idx] <= SW'(pix_y);
`endif
      end else begin
        tbl_area_q[pix_idx] <= tbl_area_q[pix_idx] + CW'(1);
        if (pix_x < tbl_xmin_q[pix_idx]) tbl_xmin_q[pix_idx] <= pix_x;
        if (pix_x > tbl_xmax_q[pix_idx]) tbl_xmax_q[pix_idx] <= pix_x;
        if (pix_y < tbl_ymin_q[pix_idx]) tbl_ymin_q[pix_idx] <= pix_y;
        if (pix_y > tbl_ymax_q[pix_idx]) tbl_ymax_q[pix_idx] <= pix_y;
`ifdef CLE_LABEL_STATS_CENTROID_EN
        tbl_sumx_q[pix_idx] <= tbl_sumx_q[pix_idx] + SW'(pix_x);
        tbl_sumy_q[pix_idx] <= tbl_sumy_q[pix_idx] + SW'(pix_y);
`endif
      end
    end
  end

  assign sram_a    = sram_a_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overflow  = ovf_q;
  assign rec_valid = rec_valid_q;
  assign rec_label = rec_label_q;
  assign rec_area  = rec_area_q;
  assign rec_xmin  = rec_xmin_q;
  assign rec_xmax  = rec_xmax_q;
  assign rec_ymin  = rec_ymin_q;
  assign rec_ymax  = rec_ymax_q;
`ifdef CLE_LABEL_STATS_CENTROID_EN
  assign rec_sumx  = rec_sumx_q;
  assign rec_sumy  = rec_sumy_q;
`endif

endmodule

// File: tb/tb_cle_label_stats.sv
// Self-checking bench for cle_label_stats: SRAM model, label-map reference
// model computed directly from the pixel array, directed and random scans.
module tb_cle_label_stats;

  localparam int MAXL = 16;
  localparam int SIDE = 32;
  localparam int NPIX = SIDE * SIDE;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  sram_q;
  logic [9:0]  sram_a;
  logic        busy, done, overflow;
  logic        rec_valid, rec_ready;
  logic [7:0]  rec_label;
  logic [10:0] rec_area;
  logic [4:0]  rec_xmin, rec_xmax, rec_ymin, rec_ymax;
`ifdef CLE_LABEL_STATS_CENTROID_EN
  logic [14:0] rec_sumx, rec_sumy;
`endif

  cle_label_stats #(
    .MAX_LABELS(MAXL),
    .IMG_LOG2  (5)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .sram_q   (sram_q),
    .sram_a   (sram_a),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .rec_valid(rec_valid),
    .rec_ready(rec_ready),
    .rec_label(rec_label),
    .rec_area (rec_area),
    .rec_xmin (rec_xmin),
    .rec_xmax (rec_xmax),
    .rec_ymin (rec_ymin),
    .rec_ymax (rec_ymax)
`ifdef CLE_LABEL_STATS_CENTROID_EN
    ,
    .rec_sumx (rec_sumx),
    .rec_sumy (rec_sumy)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous-read SRAM
  logic [7:0] mem [NPIX];
  always @(posedge clk) sram_q <= mem[sram_a];

  typedef struct {
    int label;
    int area;
    int xmin;
    int xmax;
    int ymin;
    int ymax;
    int sumx;
    int sumy;
  } rec_t;

  rec_t exp_q[$];
  rec_t got_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic rec_t cur_rec();
    rec_t r;
    r.label = int'(rec_label);
    r.area  = int'(rec_area);
    r.xmin  = int'(rec_xmin);
    r.xmax  = int'(rec_xmax);
    r.ymin  = int'(rec_ymin);
    r.ymax  = int'(rec_ymax);
`ifdef CLE_LABEL_STATS_CENTROID_EN
    r.sumx  = int'(rec_sumx);
    r.sumy  = int'(rec_sumy);
`else
    r.sumx  = 0;
    r.sumy  = 0;
`endif
    return r;
  endfunction

  // Reference: for each label, gather its pixels and take count / extrema / sums.
  task automatic build_model(output bit ovf);
    exp_q.delete();
    ovf = 1'b0;
    for (int a = 0; a < NPIX; a++) begin
      if (int'(mem[a]) > MAXL) ovf = 1'b1;
    end
    for (int l = 1; l <= MAXL; l++) begin
      rec_t r;
      r.label = l; r.area = 0; r.sumx = 0; r.sumy = 0;
      r.xmin = SIDE; r.xmax = -1; r.ymin = SIDE; r.ymax = -1;
      for (int a = 0; a < NPIX; a++) begin
        if (int'(mem[a]) == l) begin
          int x;
          int y;
          x = a % SIDE;
          y = a / SIDE;
          r.area++;
          r.sumx += x;
          r.sumy += y;
          if (x < r.xmin) r.xmin = x;
          if (x > r.xmax) r.xmax = x;
          if (y < r.ymin) r.ymin = y;
          if (y > r.ymax) r.ymax = y;
        end
      end
      if (r.area > 0) exp_q.push_back(r);
    end
`ifndef CLE_LABEL_STATS_CENTROID_EN
    foreach (exp_q[i]) begin
      exp_q[i].sumx = 0;
      exp_q[i].sumy = 0;
    end
`endif
  endtask

  task automatic clear_mem();
    for (int a = 0; a < NPIX; a++) mem[a] = 8'd0;
  endtask

  task automatic fill_scn3();
    clear_mem();
    for (int a = 0; a < SIDE; a++) mem[a] = 8'd1;
    mem[NPIX-1] = 8'd2;
  endtask

  // One full scan: start, drain records, check done/busy/overflow/records.
  task automatic run(input string name, input int stall_first, input bit rand_ready,
                     input bit start_in_busy, input bit start_at_done);
    bit   exp_ovf;
    int   ndone = 0;
    int   cyc = 0;
    int   post = 0;
    int   stall_left;
    bit   captured = 1'b0;
    bit   seen_done = 1'b0;
    rec_t cap;
    rec_t cur;
    build_model(exp_ovf);
    got_q.delete();
    stall_left = stall_first;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, "_busy_on"}, busy, 1);
    while (cyc < 6000 && post < 4) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (start_in_busy && cyc == 100) start = 1'b1;
      cur = cur_rec();
      if (rec_valid && !captured) begin
        cap = cur;
        captured = 1'b1;
      end
      if (rec_valid && got_q.size() == 0 && stall_left > 0) begin
        rec_ready = 1'b0;
        stall_left--;
        check({name, "_stall_label"}, cur.label, cap.label);
        check({name, "_stall_area"}, cur.area, cap.area);
        check({name, "_stall_bbox"}, {cur.xmin[7:0], cur.xmax[7:0], cur.ymin[7:0], cur.ymax[7:0]},
              {cap.xmin[7:0], cap.xmax[7:0], cap.ymin[7:0], cap.ymax[7:0]});
        check({name, "_stall_sums"}, cur.sumx + (cur.sumy << 16), cap.sumx + (cap.sumy << 16));
      end else begin
        rec_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (rec_valid && rec_ready) got_q.push_back(cur);
      if (done) begin
        ndone++;
        seen_done = 1'b1;
        check({name, "_busy_at_done"}, busy, 0);
        if (start_at_done) start = 1'b1;
      end else if (seen_done && start_at_done) begin
        check({name, "_busy_after_done"}, busy, 0);
      end
      if (seen_done) post++;
    end
    start = 1'b0;
    rec_ready = 1'b1;
    check({name, "_done_pulses"}, ndone, 1);
    check({name, "_overflow"}, overflow, exp_ovf);
    check({name, "_rec_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      check({name, "_label"}, got_q[i].label, exp_q[i].label);
      check({name, "_area"}, got_q[i].area, exp_q[i].area);
      check({name, "_xmin"}, got_q[i].xmin, exp_q[i].xmin);
      check({name, "_xmax"}, got_q[i].xmax, exp_q[i].xmax);
      check({name, "_ymin"}, got_q[i].ymin, exp_q[i].ymin);
      check({name, "_ymax"}, got_q[i].ymax, exp_q[i].ymax);
      check({name, "_sumx"}, got_q[i].sumx, exp_q[i].sumx);
      check({name, "_sumy"}, got_q[i].sumy, exp_q[i].sumy);
    end
  endtask

  task automatic check_idle(input string name);
    check({name, "_sram_a"}, sram_a, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_done"}, done, 0);
    check({name, "_overflow"}, overflow, 0);
    check({name, "_rec_valid"}, rec_valid, 0);
    check({name, "_rec_label"}, rec_label, 0);
    check({name, "_rec_area"}, rec_area, 0);
  endtask

  initial begin
    int k;
    reset = 1'b1;
    start = 1'b0;
    rec_ready = 1'b1;
    clear_mem();
    repeat (3) @(negedge clk);
    check_idle("reset");
    reset = 1'b0;

    // 1: empty map, plus a start coincident with done
    clear_mem();
    run("empty", 0, 1'b0, 1'b0, 1'b1);

    // 2: single pixel at (1,1)
    clear_mem();
    mem[33] = 8'd3;
    run("single", 0, 1'b0, 1'b0, 1'b0);

    // 3: full top row label 1, bottom-right pixel label 2; stray start mid-scan
    fill_scn3();
    run("row", 0, 1'b0, 1'b1, 1'b0);

    // 4: back-pressure on the first record
    fill_scn3();
    run("stall", 5, 1'b0, 1'b0, 1'b0);

    // 5: out-of-range label sets overflow
    clear_mem();
    mem[10] = 8'd20;
    mem[11] = 8'd5;
    run("ovf", 0, 1'b0, 1'b0, 1'b0);

    // Full image of one label: area must reach 1024 without wrapping
    for (int a = 0; a < NPIX; a++) mem[a] = 8'd16;
    run("full", 0, 1'b0, 1'b0, 1'b0);

    // 6: reset mid-scan, then a clean rerun
    fill_scn3();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (sram_a !== 10'd500 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("rst_reach500", sram_a, 500);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle("midreset");
    run("rerun", 0, 1'b0, 1'b0, 1'b0);

    // Random label maps with random back-pressure
    for (int it = 0; it < 4; it++) begin
      for (int a = 0; a < NPIX; a++) begin
        int r;
        r = int'($urandom_range(0, 99));
        if (r < 80) mem[a] = 8'd0;
        else if (r < 98 || it == 0) mem[a] = 8'($urandom_range(1, MAXL));
        else mem[a] = 8'($urandom_range(MAXL + 1, 255));
      end
      run("rand", (it == 1) ? 3 : 0, 1'b1, 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
